// File: rtl/add_arb_sched.sv
// Two-slot round-robin arbiter in front of a pipelined 64-bit adder, with in-order tagged responses.
// Optional statistics counters (cnt_s0, cnt_s1, cnt_conflict) are built when ADD_ARB_STATS_EN is defined.
module add_arb_sched #(
   parameter int LAT  = 4,
   parameter int TAGW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s0_valid,
   input  logic            s1_valid,
   output logic            s0_ready,
   output logic            s1_ready,
   input  logic [63:0]     s0_a,
   input  logic [63:0]     s0_b,
   input  logic [63:0]     s1_a,
   input  logic [63:0]     s1_b,
   input  logic [TAGW-1:0] s0_tag,
   input  logic [TAGW-1:0] s1_tag,
   input  logic            flush,
   output logic [63:0]     add_a,
   output logic [63:0]     add_b,
   input  logic [63:0]     add_sum,
   output logic            r0_valid,
   output logic            r1_valid,
   output logic [63:0]     r_sum,
   output logic [TAGW-1:0] r_tag
`ifdef ADD_ARB_STATS_EN
   ,
   output logic [31:0]     cnt_s0,
   output logic [31:0]     cnt_s1,
   output logic [31:0]     cnt_conflict
`endif
);

   logic            rr_q, rr_d;
   logic [63:0]     add_a_q, add_a_d, add_b_q, add_b_d;
   logic [LAT:0]    vld_q, vld_d, slot_q, slot_d;
   logic [TAGW-1:0] tag_q [LAT+1];
   logic [TAGW-1:0] tag_d [LAT+1];
   logic            r0_q, r0_d, r1_q, r1_d;
   logic [63:0]     r_sum_q, r_sum_d;
   logic [TAGW-1:0] r_tag_q, r_tag_d;
   logic            acc0, acc1, rsp;

   assign s0_ready = !reset && !flush && (!s1_valid || !rr_q);
   assign s1_ready = !reset && !flush && (!s0_valid || rr_q);
   assign acc0     = s0_valid && s0_ready;
   assign acc1     = s1_valid && s1_ready;

   always_comb begin
      rr_d    = rr_q;
      add_a_d = add_a_q;
      add_b_d = add_b_q;
      if (acc0) begin
         rr_d    = 1'b1;
         add_a_d = s0_a;
         add_b_d = s0_b;
      end else if (acc1) begin
         rr_d    = 1'b0;
         add_a_d = s1_a;
         add_b_d = s1_b;
      end

      // Tracking entry k describes the op whose sum is k cycles into the adder.
      vld_d    = flush ? '0 : {vld_q[LAT-1:0], acc0 || acc1};
      slot_d   = {slot_q[LAT-1:0], acc1};
      tag_d[0] = acc1 ? s1_tag : s0_tag;
      for (int k = 1; k <= LAT; k++) tag_d[k] = tag_q[k-1];

      rsp     = vld_q[LAT] && !flush;
      r0_d    = rsp && !slot_q[LAT];
      r1_d    = rsp && slot_q[LAT];
      r_sum_d = rsp ? add_sum : r_sum_q;
      r_tag_d = rsp ? tag_q[LAT] : r_tag_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q    <= 1'b0;
         add_a_q <= '0;
         add_b_q <= '0;
         vld_q   <= '0;
         slot_q  <= '0;
         for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
         r0_q    <= 1'b0;
         r1_q    <= 1'b0;
         r_sum_q <= '0;
         r_tag_q <= '0;
      end else begin
         rr_q    <= rr_d;
         add_a_q <= add_a_d;
         add_b_q <= add_b_d;
         vld_q   <= vld_d;
         slot_q  <= slot_d;
         for (int k = 0; k <= LAT; k++) tag_q[k] <= tag_d[k];
         r0_q    <= r0_d;
         r1_q    <= r1_d;
         r_sum_q <= r_sum_d;
         r_tag_q <= r_tag_d;
      end
   end

   assign add_a    = add_a_q;
   assign add_b    = add_b_q;
   assign r0_valid = r0_q;
   assign r1_valid = r1_q;
   assign r_sum    = r_sum_q;
   assign r_tag    = r_tag_q;

`ifdef ADD_ARB_STATS_EN
   logic [31:0] cnt_s0_q, cnt_s1_q, cnt_conf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_s0_q   <= '0;
         cnt_s1_q   <= '0;
         cnt_conf_q <= '0;
      end else begin
         if (acc0) cnt_s0_q <= cnt_s0_q + 32'd1;
         if (acc1) cnt_s1_q <= cnt_s1_q + 32'd1;
         if (s0_valid && s1_valid && !flush) cnt_conf_q <= cnt_conf_q + 32'd1;
      end
   end

   assign cnt_s0       = cnt_s0_q;
   assign cnt_s1       = cnt_s1_q;
   assign cnt_conflict = cnt_conf_q;
`endif

endmodule
